phase_gen: RTL and testbench

- Upstream feeder for the CORDIC sine/cosine stage.
- Generates a stream of signed fixed-point phase words (radians) using a phase accumulator with a programmable signed step.
- Wraps each word into [-PI, PI) and writes it into the stage's 32-bit input FIFO, honouring that FIFO's full flag.
- Supports fixed-length bursts and free-running mode with software stop.

---
 rtl/phase_gen.sv | 132 +++++++++++++
 tb/tb_phase_gen.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_gen.sv
// Phase accumulator feeding the CORDIC input FIFO: emits signed fixed-point
// radian words wrapped into [-PI, PI), in bursts or free-running until stopped.
//
// state | meaning
// IDLE  | waiting for start; outputs quiet, error holds
// RUN   | writing one phase word per non-full cycle
module phase_gen #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 14,
    parameter int PI_FIXED   = 51472,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic [DATA_WIDTH-1:0] step,
    input  logic [DATA_WIDTH-1:0] phase_init,
    input  logic [CNT_WIDTH-1:0]  count,
    input  logic                  out_full,
    output logic                  out_wr_en,
    output logic [DATA_WIDTH-1:0] out_phase,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    typedef enum logic {IDLE, RUN} state_t;

    // Range checks and wrapping use one extra bit so phase+step cannot overflow.
    localparam logic signed [DATA_WIDTH:0] PI_W     = (DATA_WIDTH+1)'(PI_FIXED);
    localparam logic signed [DATA_WIDTH:0] NEG_PI_W = -PI_W;
    localparam logic signed [DATA_WIDTH:0] TWO_PI_W = (DATA_WIDTH+1)'(2 * PI_FIXED);

    state_t                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   phase_q, phase_d;
    logic [DATA_WIDTH-1:0]   step_q, step_d;
    logic [CNT_WIDTH-1:0]    remaining_q, remaining_d;
    logic                    free_q, free_d;
    logic                    error_q, error_d;
    logic                    done_q, done_d;

    logic signed [DATA_WIDTH:0] step_in_ext, init_in_ext;
    logic signed [DATA_WIDTH:0] phase_ext, step_ext, nxt, wrapped;
    logic                       start_legal;

    assign step_in_ext = $signed({step[DATA_WIDTH-1], step});
    assign init_in_ext = $signed({phase_init[DATA_WIDTH-1], phase_init});
    assign phase_ext   = $signed({phase_q[DATA_WIDTH-1], phase_q});
    assign step_ext    = $signed({step_q[DATA_WIDTH-1], step_q});

    assign start_legal = (step_in_ext >= NEG_PI_W) && (step_in_ext <= PI_W) &&
                         (init_in_ext >= NEG_PI_W) && (init_in_ext < PI_W);

    assign nxt = phase_ext + step_ext;

    always_comb begin
        wrapped = nxt;
        if (nxt >= PI_W) begin
            wrapped = nxt - TWO_PI_W;
        end else if (nxt < NEG_PI_W) begin
            wrapped = nxt + TWO_PI_W;
        end
    end

    assign busy      = (state_q == RUN);
    assign out_wr_en = busy & ~out_full;
    assign out_phase = phase_q;
    assign done      = done_q;
    assign error     = error_q;

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        step_d      = step_q;
        remaining_d = remaining_q;
        free_d      = free_q;
        error_d     = error_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (start_legal) begin
                        step_d      = step;
                        phase_d     = phase_init;
                        remaining_d = count;
                        free_d      = (count == '0);
                        error_d     = 1'b0;
                        state_d     = RUN;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (out_wr_en) begin
                    phase_d = wrapped[DATA_WIDTH-1:0];
                    if (!free_q) begin
                        remaining_d = remaining_q - CNT_WIDTH'(1);
                    end
                end
                // A write in the same cycle as stop has already been taken above.
                if (stop || (out_wr_en && !free_q && remaining_q == CNT_WIDTH'(1))) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            phase_q     <= '0;
            step_q      <= '0;
            remaining_q <= '0;
            free_q      <= 1'b0;
            error_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            step_q      <= step_d;
            remaining_q <= remaining_d;
            free_q      <= free_d;
            error_q     <= error_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_phase_gen.sv
// Directed bench for phase_gen: burst wrap, backpressure, negative step,
// illegal start, free-run with stop, and asynchronous reset mid-burst.
module tb_phase_gen;

    logic        clock;
    logic        reset;
    logic        start;
    logic        stop;
    logic [31:0] step;
    logic [31:0] phase_init;
    logic [15:0] count;
    logic        out_full;
    logic        out_wr_en;
    logic [31:0] out_phase;
    logic        busy;
    logic        done;
    logic        error;

    int total = 0;
    int bad   = 0;

    int got[$];
    int done_cnt;
    int done_at;
    int wr_while_full;

    phase_gen dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .step       (step),
        .phase_init (phase_init),
        .count      (count),
        .out_full   (out_full),
        .out_wr_en  (out_wr_en),
        .out_phase  (out_phase),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic do_start(input int s, input int init, input int c);
        @(negedge clock);
        step       = s;
        phase_init = init;
        count      = 16'(c);
        start      = 1'b1;
        stop       = 1'b0;
        out_full   = 1'b0;
    endtask

    task automatic run(input int ncyc, input int full_lo, input int full_hi,
                       input int stop_at, input int start_at);
        got.delete();
        done_cnt      = 0;
        done_at       = -1;
        wr_while_full = 0;
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clock);
            start    = 1'b0;
            stop     = (i == stop_at);
            out_full = (i >= full_lo) && (i <= full_hi);
            if (i == start_at) begin
                step       = 5;
                phase_init = 3;
                count      = 2;
                start      = 1'b1;
            end
            #1;
            if (out_wr_en) got.push_back(int'(out_phase));
            if (out_wr_en && out_full) wr_while_full++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = i;
            end
        end
        @(negedge clock);
        start    = 1'b0;
        stop     = 1'b0;
        out_full = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 0; stop = 0; step = 0; phase_init = 0; count = 0; out_full = 0;
        repeat (2) @(negedge clock);
        #1;
        total++;
        if ({out_wr_en, busy, done, error} !== 4'b0000 || out_phase !== 32'd0) begin
            bad++;
            $display("FAIL reset_outputs: got wr=%b busy=%b done=%b err=%b ph=%0d want all 0",
                     out_wr_en, busy, done, error, out_phase);
        end
        reset = 1'b0;
    endtask

    task automatic test_burst_wrap();
        int exp[9] = '{0, 12868, 25736, 38604, -51472, -38604, -25736, -12868, 0};
        do_start(12868, 0, 9);
        run(14, -1, -1, -1, -1);
        total++;
        if (got.size() != 9) begin
            bad++;
            $display("FAIL burst_count: got %0d writes want 9", got.size());
        end
        for (int i = 0; i < 9 && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++;
                $display("FAIL burst_word%0d: got %0d want %0d", i, got[i], exp[i]);
            end
        end
        total++;
        if (done_cnt !== 1 || done_at !== 10) begin
            bad++;
            $display("FAIL burst_done: got cnt=%0d at=%0d want cnt=1 at=10", done_cnt, done_at);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++;
            $display("FAIL burst_busy_end: got %b want 0", busy);
        end
    endtask

    task automatic test_backpressure();
        int exp[9] = '{0, 12868, 25736, 38604, -51472, -38604, -25736, -12868, 0};
        do_start(12868, 0, 9);
        run(18, 3, 6, -1, -1);
        total++;
        if (got.size() != 9) begin
            bad++;
            $display("FAIL bp_count: got %0d writes want 9", got.size());
        end
        for (int i = 0; i < 9 && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++;
                $display("FAIL bp_word%0d: got %0d want %0d", i, got[i], exp[i]);
            end
        end
        total++;
        if (wr_while_full !== 0) begin
            bad++;
            $display("FAIL bp_wr_while_full: got %0d want 0", wr_while_full);
        end
        total++;
        if (done_cnt !== 1 || done_at !== 14) begin
            bad++;
            $display("FAIL bp_done: got cnt=%0d at=%0d want cnt=1 at=14", done_cnt, done_at);
        end
    endtask

    task automatic test_negative_step();
        int exp[3] = '{-38604, 38604, 12868};
        do_start(-25736, -38604, 3);
        run(7, -1, -1, -1, -1);
        total++;
        if (got.size() != 3) begin
            bad++;
            $display("FAIL neg_count: got %0d writes want 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++;
                $display("FAIL neg_word%0d: got %0d want %0d", i, got[i], exp[i]);
            end
        end
        total++;
        if (done_at !== 4) begin
            bad++;
            $display("FAIL neg_done: got at=%0d want 4", done_at);
        end
    endtask

    task automatic test_boundary();
        int exp[3] = '{-51472, 0, -51472};
        do_start(51472, -51472, 3);
        run(6, -1, -1, -1, -1);
        total++;
        if (got.size() != 3) begin
            bad++;
            $display("FAIL bound_count: got %0d writes want 3", got.size());
        end
        for (int i = 0; i < 3 && i < got.size(); i++) begin
            total++;
            if (got[i] !== exp[i]) begin
                bad++;
                $display("FAIL bound_word%0d: got %0d want %0d", i, got[i], exp[i]);
            end
        end
        total++;
        if (error !== 1'b0) begin
            bad++;
            $display("FAIL bound_error: got %b want 0", error);
        end
    endtask

    task automatic test_illegal_start();
        do_start(51473, 0, 5);
        run(5, -1, -1, -1, -1);
        total++;
        if (error !== 1'b1 || busy !== 1'b0 || got.size() != 0) begin
            bad++;
            $display("FAIL illegal_step: got err=%b busy=%b writes=%0d want err=1 busy=0 writes=0",
                     error, busy, got.size());
        end
        do_start(100, 777, 1);
        run(4, -1, -1, -1, -1);
        total++;
        if (error !== 1'b0 || got.size() != 1) begin
            bad++;
            $display("FAIL legal_after: got err=%b writes=%0d want err=0 writes=1", error, got.size());
        end else begin
            total++;
            if (got[0] !== 777) begin
                bad++;
                $display("FAIL legal_after_word: got %0d want 777", got[0]);
            end
        end
        total++;
        if (done_at !== 2) begin
            bad++;
            $display("FAIL legal_after_done: got at=%0d want 2", done_at);
        end
        do_start(10, 51472, 2);
        run(3, -1, -1, -1, -1);
        total++;
        if (error !== 1'b1 || got.size() != 0) begin
            bad++;
            $display("FAIL illegal_init: got err=%b writes=%0d want err=1 writes=0", error, got.size());
        end
    endtask

    task automatic test_free_run_stop();
        do_start(1000, 0, 0);
        run(12, -1, -1, 6, 3);
        total++;
        if (got.size() != 6) begin
            bad++;
            $display("FAIL free_count: got %0d writes want 6", got.size());
        end
        for (int i = 0; i < 6 && i < got.size(); i++) begin
            total++;
            if (got[i] !== i * 1000) begin
                bad++;
                $display("FAIL free_word%0d: got %0d want %0d", i, got[i], i * 1000);
            end
        end
        total++;
        if (done_cnt !== 1 || done_at !== 7 || busy !== 1'b0) begin
            bad++;
            $display("FAIL free_done: got cnt=%0d at=%0d busy=%b want cnt=1 at=7 busy=0",
                     done_cnt, done_at, busy);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_start(12868, 0, 9);
        run(4, -1, -1, -1, -1);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (out_wr_en !== 1'b0 || busy !== 1'b0 || out_phase !== 32'd0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: got wr=%b busy=%b ph=%0d done=%b want all 0",
                     out_wr_en, busy, out_phase, done);
        end
        @(negedge clock);
        reset = 1'b0;
        run(4, -1, -1, -1, -1);
        total++;
        if (done_cnt !== 0 || got.size() != 0) begin
            bad++;
            $display("FAIL reset_no_done: got done=%0d writes=%0d want 0 0", done_cnt, got.size());
        end
        do_start(12868, 0, 2);
        run(5, -1, -1, -1, -1);
        total++;
        if (got.size() != 2) begin
            bad++;
            $display("FAIL reset_fresh_count: got %0d writes want 2", got.size());
        end else begin
            total++;
            if (got[0] !== 0 || got[1] !== 12868) begin
                bad++;
                $display("FAIL reset_fresh_words: got %0d %0d want 0 12868", got[0], got[1]);
            end
        end
        total++;
        if (done_at !== 3) begin
            bad++;
            $display("FAIL reset_fresh_done: got at=%0d want 3", done_at);
        end
    endtask

    initial begin
        test_reset();
        test_burst_wrap();
        test_backpressure();
        test_negative_step();
        test_boundary();
        test_illegal_start();
        test_free_run_stop();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
